// File: rtl/prbs_ber_checker.sv
// Self-synchronising PRBS bit-error-rate checker.
// Locks onto a Fibonacci PRBS (x^TAP_A + x^TAP_B + 1) in the incoming serial stream, then counts
// checked bits and bit errors. Lock is dropped when a window of WIN_LEN checked bits collects
// LOSS_THRESH errors, after which the checker re-synchronises on its own.
module prbs_ber_checker #(
    parameter int unsigned PRBS_ORDER  = 7,
    parameter int unsigned TAP_A       = 7,
    parameter int unsigned TAP_B       = 6,
    parameter int unsigned VERIFY_LEN  = 16,
    parameter int unsigned WIN_LEN     = 64,
    parameter int unsigned LOSS_THRESH = 8,
    parameter int unsigned ERR_W       = 16,
    parameter int unsigned BIT_W       = 32
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             data_in,
    input  logic             data_valid,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt,
    output logic [BIT_W-1:0] bit_cnt
);

    localparam int unsigned FillW = $clog2(PRBS_ORDER + 1);
    localparam int unsigned MatchW = $clog2(VERIFY_LEN + 1);
    localparam int unsigned WinBitW = $clog2(WIN_LEN + 1);
    localparam int unsigned WinErrW = $clog2(LOSS_THRESH + 1);

    localparam logic [FillW-1:0] FillLast = FillW'(PRBS_ORDER - 1);
    localparam logic [MatchW-1:0] MatchLast = MatchW'(VERIFY_LEN - 1);
    localparam logic [WinBitW-1:0] WinLen = WinBitW'(WIN_LEN);
    localparam logic [WinErrW-1:0] LossThr = WinErrW'(LOSS_THRESH);

    typedef enum logic [1:0] {
        StSearch,
        StVerify,
        StLocked
    } state_e;

    state_e                state_q, state_d;
    logic [PRBS_ORDER-1:0] s_q, s_d;
    logic [FillW-1:0]      fill_q, fill_d;
    logic [MatchW-1:0]     match_q, match_d;
    logic [WinBitW-1:0]    win_bit_q, win_bit_d;
    logic [WinErrW-1:0]    win_err_q, win_err_d;
    logic [ERR_W-1:0]      err_cnt_q, err_cnt_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic                  err_pulse_q, err_pulse_d;

    logic                  pred;
    logic                  bit_err;
    logic [WinBitW-1:0]    win_bit_nxt;
    logic [WinErrW-1:0]    win_err_nxt;

    // Prediction and window bookkeeping for the bit currently on data_in.
    always_comb begin
        pred        = s_q[TAP_A-1] ^ s_q[TAP_B-1];
        bit_err     = data_in ^ pred;
        win_bit_nxt = win_bit_q + WinBitW'(1);
        win_err_nxt = bit_err ? (win_err_q + WinErrW'(1)) : win_err_q;
    end

    // Next-state logic for the lock FSM, the LFSR and all counters.
    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        fill_d      = fill_q;
        match_d     = match_q;
        win_bit_d   = win_bit_q;
        win_err_d   = win_err_q;
        err_cnt_d   = err_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        err_pulse_d = 1'b0;

        if (data_valid) begin
            unique case (state_q)
                StSearch: begin
                    s_d = {s_q[PRBS_ORDER-2:0], data_in};
                    if (fill_q == FillLast) begin
                        state_d = StVerify;
                        fill_d  = '0;
                        match_d = '0;
                    end else begin
                        fill_d = fill_q + FillW'(1);
                    end
                end

                StVerify: begin
                    // Received bits keep loading the LFSR until the phase is trusted.
                    s_d = {s_q[PRBS_ORDER-2:0], data_in};
                    if (bit_err) begin
                        state_d = StSearch;
                        fill_d  = '0;
                    end else if (match_q == MatchLast) begin
                        state_d   = StLocked;
                        win_bit_d = '0;
                        win_err_d = '0;
                    end else begin
                        match_d = match_q + MatchW'(1);
                    end
                end

                StLocked: begin
                    // Free-run on the prediction so channel errors cannot poison the LFSR.
                    s_d = {s_q[PRBS_ORDER-2:0], pred};
                    if (bit_cnt_q != '1) begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                    if (bit_err && (err_cnt_q != '1)) begin
                        err_cnt_d = err_cnt_q + ERR_W'(1);
                    end
                    if (win_err_nxt >= LossThr) begin
                        // The losing bit gets no pulse: err_pulse never shows with locked low.
                        state_d   = StSearch;
                        fill_d    = '0;
                        win_bit_d = '0;
                        win_err_d = '0;
                    end else begin
                        err_pulse_d = bit_err;
                        if (win_bit_nxt == WinLen) begin
                            win_bit_d = '0;
                            win_err_d = '0;
                        end else begin
                            win_bit_d = win_bit_nxt;
                            win_err_d = win_err_nxt;
                        end
                    end
                end

                default: begin
                    state_d = StSearch;
                    fill_d  = '0;
                end
            endcase
        end

        // Clear wins over any increment on the same edge; lock state is untouched.
        if (clear) begin
            err_cnt_d = '0;
            bit_cnt_d = '0;
            win_bit_d = '0;
            win_err_d = '0;
        end
    end

    // State and counter registers with asynchronous active-low reset.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StSearch;
            s_q         <= '0;
            fill_q      <= '0;
            match_q     <= '0;
            win_bit_q   <= '0;
            win_err_q   <= '0;
            err_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            fill_q      <= fill_d;
            match_q     <= match_d;
            win_bit_q   <= win_bit_d;
            win_err_q   <= win_err_d;
            err_cnt_q   <= err_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            err_pulse_q <= err_pulse_d;
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        locked    = (state_q == StLocked);
        err_pulse = err_pulse_q;
        err_cnt   = err_cnt_q;
        bit_cnt   = bit_cnt_q;
    end

endmodule

// File: tb/tb_prbs_ber_checker.sv
// Randomised self-checking bench for prbs_ber_checker (default instance plus an ERR_W=4 copy).
module tb_prbs_ber_checker;

    localparam int Order  = 7;
    localparam int TapA   = 7;
    localparam int TapB   = 6;
    localparam int VerLen = 16;
    localparam int WinLen = 64;
    localparam int Thresh = 8;

    logic        clk_in;
    logic        rst_n;
    logic        data_in;
    logic        data_valid;
    logic        clear;
    logic        locked, err_pulse;
    logic [15:0] err_cnt;
    logic [31:0] bit_cnt;
    logic        locked4, err_pulse4;
    logic [3:0]  err_cnt4;
    logic [31:0] bit_cnt4;

    int n_checks = 0;
    int n_bad    = 0;

    prbs_ber_checker dut (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .data_valid (data_valid),
        .clear      (clear),
        .locked     (locked),
        .err_pulse  (err_pulse),
        .err_cnt    (err_cnt),
        .bit_cnt    (bit_cnt)
    );

    prbs_ber_checker #(.ERR_W(4)) dut4 (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .data_valid (data_valid),
        .clear      (clear),
        .locked     (locked4),
        .err_pulse  (err_pulse4),
        .err_cnt    (err_cnt4),
        .bit_cnt    (bit_cnt4)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Source: x[n] = x[n-TapA] ^ x[n-TapB], held as a sliding list of past bits.
    bit gq[$];

    // Reference checker: behaviour stated as rules over the history of expected bits.
    bit          hist[$];
    int          m_mode;   // 0 search, 1 verify, 2 locked
    int          m_fill, m_match, m_w, m_we;
    logic [15:0] m_e16;
    logic [3:0]  m_e4;
    logic [31:0] m_bits;
    logic        m_pulse;

    task automatic next_prbs(output logic b);
        b = gq[gq.size() - TapA] ^ gq[gq.size() - TapB];
        gq.push_back(b);
        void'(gq.pop_front());
    endtask

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < Order; i++) hist.push_back(1'b0);
        m_mode = 0; m_fill = 0; m_match = 0; m_w = 0; m_we = 0;
        m_e16 = '0; m_e4 = '0; m_bits = '0; m_pulse = 1'b0;
    endtask

    task automatic model_step(input logic v, input logic d, input logic clr);
        logic p, e;
        m_pulse = 1'b0;
        if (v) begin
            p = hist[Order - TapA] ^ hist[Order - TapB];
            e = d ^ p;
            if (m_mode == 0) begin
                hist.push_back(d);
                m_fill++;
                if (m_fill == Order) begin m_mode = 1; m_match = 0; end
            end else if (m_mode == 1) begin
                hist.push_back(d);
                if (e) begin
                    m_mode = 0; m_fill = 0;
                end else begin
                    m_match++;
                    if (m_match == VerLen) begin m_mode = 2; m_w = 0; m_we = 0; end
                end
            end else begin
                hist.push_back(p);
                if (m_bits != 32'hffff_ffff) m_bits = m_bits + 1;
                m_w++;
                if (e) begin
                    if (m_e16 != 16'hffff) m_e16 = m_e16 + 1;
                    if (m_e4 != 4'hf) m_e4 = m_e4 + 1;
                    m_we++;
                end
                if (m_we >= Thresh) begin
                    m_mode = 0; m_fill = 0;
                end else begin
                    m_pulse = e;
                    if (m_w == WinLen) begin m_w = 0; m_we = 0; end
                end
            end
            void'(hist.pop_front());
        end
        if (clr) begin
            m_bits = '0; m_e16 = '0; m_e4 = '0; m_w = 0; m_we = 0;
        end
    endtask

    function automatic logic [87:0] obs_vec();
        return {locked, err_pulse, err_cnt, bit_cnt, locked4, err_pulse4, err_cnt4, bit_cnt4};
    endfunction

    function automatic logic [87:0] exp_vec();
        logic l;
        l = (m_mode == 2);
        return {l, m_pulse, m_e16, m_bits, l, m_pulse, m_e4, m_bits};
    endfunction

    // One cycle: drive at the falling edge, let the rising edge consume, sample 1 time unit later.
    task automatic step(input logic v, input logic flip, input logic clr);
        logic b;
        @(negedge clk_in);
        if (v) begin
            next_prbs(b);
            b = b ^ flip;
        end else begin
            b = 1'($urandom_range(0, 1));
        end
        data_valid = v;
        data_in    = b;
        clear      = clr;
        model_step(v, b, clr);
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        data_valid = 1'b0;
        clear = 1'b0;
        model_reset();
        repeat (2) @(negedge clk_in);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_checks++;
        if (obs_vec() !== 88'h0) begin
            n_bad++;
            $display("FAIL reset: outputs=%h required=0", obs_vec());
        end
    endtask

    task automatic test_clean_lock();
        int n = 0;
        while (!locked && n < 200) begin
            step(1'b1, 1'b0, 1'b0);
            n++;
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL clean_acquire bit %0d: got=%h want=%h", n, obs_vec(), exp_vec());
            end
        end
        n_checks++;
        if (n != 23) begin
            n_bad++;
            $display("FAIL lock_latency: got=%0d bits want=23", n);
        end
        repeat (1000) begin
            step(1'b1, 1'b0, 1'b0);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL clean_run: got=%h want=%h", obs_vec(), exp_vec());
            end
        end
        n_checks++;
        if (bit_cnt !== 32'd1000 || err_cnt !== 16'd0) begin
            n_bad++;
            $display("FAIL clean_counts: bit_cnt=%0d err_cnt=%0d want 1000/0", bit_cnt, err_cnt);
        end
    endtask

    task automatic test_isolated_errors();
        int pulses = 0;
        for (int i = 0; i < 300; i++) begin
            step(1'b1, (i % 100) == 50, 1'b0);
            if (err_pulse) pulses++;
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL isolated bit %0d: got=%h want=%h", i, obs_vec(), exp_vec());
            end
        end
        n_checks++;
        if (pulses != 3 || err_cnt !== 16'd3 || locked !== 1'b1) begin
            n_bad++;
            $display("FAIL isolated_summary: pulses=%0d err_cnt=%0d locked=%b want 3/3/1",
                     pulses, err_cnt, locked);
        end
    endtask

    task automatic test_loss_relock();
        int n = 0;
        int pulses = 0;
        step(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            step(1'b1, i[0], 1'b0);
            if (err_pulse) pulses++;
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL loss bit %0d: got=%h want=%h", i, obs_vec(), exp_vec());
            end
        end
        n_checks++;
        if (locked !== 1'b0 || err_cnt !== 16'd8 || pulses != 7 || bit_cnt !== 32'd16) begin
            n_bad++;
            $display("FAIL loss_summary: locked=%b err_cnt=%0d pulses=%0d bit_cnt=%0d want 0/8/7/16",
                     locked, err_cnt, pulses, bit_cnt);
        end
        while (!locked && n < 200) begin
            step(1'b1, 1'b0, 1'b0);
            n++;
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL relock bit %0d: got=%h want=%h", n, obs_vec(), exp_vec());
            end
        end
        step(1'b1, 1'b0, 1'b0);
        n_checks++;
        if (n != 23 || err_cnt !== 16'd8 || bit_cnt !== 32'd17) begin
            n_bad++;
            $display("FAIL relock_summary: bits=%0d err_cnt=%0d bit_cnt=%0d want 23/8/17",
                     n, err_cnt, bit_cnt);
        end
    endtask

    task automatic test_valid_toggle();
        int cyc = 0;
        int nv = 0;
        do_reset();
        while (!locked && cyc < 200) begin
            step(cyc % 2 == 0, 1'b0, 1'b0);
            if (cyc % 2 == 0) nv++;
            cyc++;
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL toggle_acquire cyc %0d: got=%h want=%h", cyc, obs_vec(), exp_vec());
            end
        end
        n_checks++;
        if (nv != 23 || cyc != 45) begin
            n_bad++;
            $display("FAIL toggle_latency: valid=%0d cycles=%0d want 23/45", nv, cyc);
        end
        for (int i = 0; i < 40; i++) begin
            step(i % 2 == 1, 1'b0, 1'b0);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL toggle_run cyc %0d: got=%h want=%h", i, obs_vec(), exp_vec());
            end
        end
        n_checks++;
        if (bit_cnt !== 32'd20) begin
            n_bad++;
            $display("FAIL toggle_bits: bit_cnt=%0d want 20", bit_cnt);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 384; i++) begin
            step(1'b1, (m_w % 16) == 5, 1'b0);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL saturate bit %0d: got=%h want=%h", i, obs_vec(), exp_vec());
            end
        end
        n_checks++;
        if (err_cnt4 !== 4'd15 || err_cnt !== 16'd24 || locked !== 1'b1) begin
            n_bad++;
            $display("FAIL saturate_summary: err4=%0d err16=%0d locked=%b want 15/24/1",
                     err_cnt4, err_cnt, locked);
        end
        step(1'b1, 1'b1, 1'b1);
        n_checks++;
        if (err_cnt !== 16'd0 || err_cnt4 !== 4'd0 || bit_cnt !== 32'd0 || err_pulse !== 1'b1) begin
            n_bad++;
            $display("FAIL clear_with_error: err16=%0d err4=%0d bits=%0d pulse=%b want 0/0/0/1",
                     err_cnt, err_cnt4, bit_cnt, err_pulse);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 59) == 0,
                 $urandom_range(0, 299) == 0);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL random cyc %0d: got=%h want=%h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_async_reset();
        int n = 0;
        while (!locked && n < 200) begin
            step(1'b1, 1'b0, 1'b0);
            n++;
        end
        repeat (50) step(1'b1, 1'b0, 1'b0);
        n_checks++;
        if (locked !== 1'b1 || bit_cnt === 32'd0) begin
            n_bad++;
            $display("FAIL pre_reset_lock: locked=%b bit_cnt=%0d want 1/nonzero", locked, bit_cnt);
        end
        #2;
        rst_n = 1'b0;
        data_valid = 1'b0;
        clear = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (obs_vec() !== 88'h0) begin
            n_bad++;
            $display("FAIL async_reset: outputs=%h required=0", obs_vec());
        end
        repeat (2) @(negedge clk_in);
        rst_n = 1'b1;
        n = 0;
        while (!locked && n < 200) begin
            step(1'b1, 1'b0, 1'b0);
            n++;
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL post_reset bit %0d: got=%h want=%h", n, obs_vec(), exp_vec());
            end
        end
        n_checks++;
        if (n != 23) begin
            n_bad++;
            $display("FAIL post_reset_latency: got=%0d bits want=23", n);
        end
    endtask

    initial begin
        logic [6:0] seed;
        rst_n = 1'b0;
        data_in = 1'b0;
        data_valid = 1'b0;
        clear = 1'b0;
        seed = 7'($urandom_range(1, 127));
        for (int i = 0; i < Order; i++) gq.push_back(seed[i]);
        model_reset();

        test_reset();
        test_clean_lock();
        test_isolated_errors();
        test_loss_relock();
        test_valid_toggle();
        test_saturation();
        test_random();
        test_async_reset();

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
